// File: rtl/lvds_rx_pkg.sv
// Shared constants and helpers for the LVDS receive lane array.
// Defaults here set the main ADC path configuration.
package lvds_rx_pkg;

    localparam string LVDS_IOSTANDARD = "LVDS";

    localparam int    DEF_NUM_LANES   = 8;
    localparam int    DEF_SYNC_STAGES = 2;
    localparam int    DEF_FILTER_LEN  = 4;
    localparam int    DEF_TIMEOUT     = 1024;
    localparam string DEF_DIFF_TERM   = "TRUE";

    // Bits needed to hold every value 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/lvds_lane_filter.sv
// One receive lane: synchroniser, consecutive-sample glitch filter,
// registered edge strobes and an activity watchdog.
module lvds_lane_filter
    import lvds_rx_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILTER_LEN  = DEF_FILTER_LEN,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din_i,
    input  logic en_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic active_o
);

    localparam int            CW       = cnt_w(FILTER_LEN);
    localparam int            WW       = cnt_w(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);
    localparam logic [WW-1:0] WD_MAX   = WW'(TIMEOUT);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [WW-1:0]          wd_q, wd_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   active_q, active_d;

    logic s_w;
    logic mismatch_w;
    logic flip_w;

    // The synchroniser is never gated so re-enabling a lane sees settled data.
    assign sync_d     = {sync_q[SYNC_STAGES-2:0], din_i};
    assign s_w        = sync_q[SYNC_STAGES-1];
    assign mismatch_w = (s_w != level_q);
    assign flip_w     = mismatch_w && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d    = '0;
        level_d  = level_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        wd_d     = wd_q;
        active_d = (wd_q < WD_MAX);

        if (!en_i) begin
            // Forced low without a fall strobe; watchdog parked as after reset.
            level_d  = 1'b0;
            wd_d     = WD_MAX;
            active_d = 1'b0;
        end else if (flip_w) begin
            level_d = s_w;
            rise_d  = s_w;
            fall_d  = ~s_w;
            wd_d    = '0;
        end else begin
            if (mismatch_w) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (wd_q < WD_MAX) begin
                wd_d = wd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            level_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            wd_q     <= WD_MAX;
            active_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            wd_q     <= wd_d;
            active_q <= active_d;
        end
    end

    assign level_o  = level_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign active_o = active_q;

endmodule

// File: rtl/lvds_rx_ibufds.sv
// Behavioural differential input buffer with the same parameters as IBUFDS.
// An undriven (equal-leg) terminated pair resolves low, giving a fail-safe idle.
module lvds_rx_ibufds
    import lvds_rx_pkg::*;
#(
    parameter string IOSTANDARD = LVDS_IOSTANDARD,
    parameter string DIFF_TERM  = DEF_DIFF_TERM
) (
    input  logic pad_p_i,
    input  logic pad_n_i,
    output logic buf_o
);

    localparam bit IS_DIFF = (IOSTANDARD == "LVDS");
    localparam bit TERM_EN = (DIFF_TERM == "TRUE");

    always_comb begin
        buf_o = pad_p_i;
        if (IS_DIFF && TERM_EN && (pad_p_i == pad_n_i)) begin
            buf_o = 1'b0;
        end
    end

endmodule

// File: rtl/lvds_rx_lane_array.sv
// Multi-lane LVDS receive front end: per lane a differential buffer,
// optional pair-swap inversion, then an independent filter lane.
module lvds_rx_lane_array
    import lvds_rx_pkg::*;
#(
    parameter int                   NUM_LANES   = DEF_NUM_LANES,
    parameter int                   SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int                   FILTER_LEN  = DEF_FILTER_LEN,
    parameter int                   TIMEOUT     = DEF_TIMEOUT,
    parameter logic [NUM_LANES-1:0] INVERT_MASK = '0,
    parameter string                DIFF_TERM   = DEF_DIFF_TERM
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_LANES-1:0] diff_p,
    input  logic [NUM_LANES-1:0] diff_n,
    input  logic [NUM_LANES-1:0] lane_en,
    output logic [NUM_LANES-1:0] lane_out,
    output logic [NUM_LANES-1:0] rise_pulse,
    output logic [NUM_LANES-1:0] fall_pulse,
    output logic [NUM_LANES-1:0] lane_active
);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic pad_lvl;
        logic lane_in;

        lvds_rx_ibufds #(
            .IOSTANDARD (LVDS_IOSTANDARD),
            .DIFF_TERM  (DIFF_TERM)
        ) u_ibuf (
            .pad_p_i (diff_p[i]),
            .pad_n_i (diff_n[i]),
            .buf_o   (pad_lvl)
        );

        // Undo a swapped P/N pair on the board.
        assign lane_in = pad_lvl ^ INVERT_MASK[i];

        lvds_lane_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_LEN  (FILTER_LEN),
            .TIMEOUT     (TIMEOUT)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .din_i    (lane_in),
            .en_i     (lane_en[i]),
            .level_o  (lane_out[i]),
            .rise_o   (rise_pulse[i]),
            .fall_o   (fall_pulse[i]),
            .active_o (lane_active[i])
        );
    end

endmodule
